reg_share_arbiter: RTL and testbench

Round-robin write arbiter that shares one WIDTH-bit D-flip-flop register between N_REQ requesters. Each cycle it selects at most one requesting client and loads that client's data into the shared register. The register drives complementary outputs q/qb, and the block returns a one-cycle grant pulse to the winner. It sits between client blocks and the shared storage element, and it is the only writer of that storage.

---
 rtl/reg_share_arbiter_pkg.sv | 34 +++
 rtl/reg_share_arbiter_if.sv | 22 ++
 rtl/reg_share_arbiter_bank.sv | 26 ++
 rtl/reg_share_arbiter.sv | 68 ++++++
 tb/tb_reg_share_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and the round-robin selection function for the register-sharing arbiter.
package reg_share_pkg;

  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;

  typedef struct packed {
    logic              valid;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Returns the first set bit of req at or after ptr, wrapping within n_req requesters.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int                 n_req);
    pick_t pick;
    int    cand;
    pick = '0;
    cand = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n_req) begin
        cand = int'(ptr) + k;
        if (cand >= n_req) cand = cand - n_req;
        if (!pick.valid && req[cand[PICK_W-1:0]]) begin
          pick.valid = 1'b1;
          pick.idx   = PICK_W'(cand);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Client-side bundle of the shared-register arbiter: requests, data, clear and results.
interface reg_share_arbiter_if
  import reg_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic                   clr;
  logic [N_REQ-1:0]       gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qb;
  logic [CNT_W-1:0]       wr_cnt;

  modport master (output req, wdata, clr, input gnt, gnt_idx, q, qb, wr_cnt);
  modport slave  (input req, wdata, clr, output gnt, gnt_idx, q, qb, wr_cnt);

endinterface

// File: rtl/reg_share_arbiter_bank.sv
// Shared WIDTH-bit storage register with synchronous clear, load enable and complementary outputs.
module dff_async_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_q;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q_q <= '0;
    else if (clr) q_q <= '0;
    else if (en)  q_q <= d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester per cycle write access to a shared register.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input logic                clk,
  input logic                rst,
  reg_share_arbiter_if.slave bus
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] win_idx;
  logic             wr_en;
  pick_t            pick;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(bus.req), PICK_W'(ptr_q), N_REQ);
    win_idx   = IDX_W'(pick.idx);
    wr_en     = pick.valid && !bus.clr;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    gnt_idx_d = gnt_idx_q;
    cnt_d     = cnt_q;
    if (wr_en) begin
      ptr_d     = (int'(win_idx) == N_REQ - 1) ? '0 : IDX_W'(win_idx + 1'b1);
      gnt_d     = N_REQ'(1) << win_idx;
      gnt_idx_d = win_idx;
      cnt_d     = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // A clear pending in the same cycle blocks the load; the bank gives clr priority.
  dff_async_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .clr (bus.clr),
    .d   (bus.wdata[int'(win_idx)*WIDTH +: WIDTH]),
    .q   (bus.q),
    .qb  (bus.qb)
  );

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.wr_cnt  = cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_reg_share_arbiter;
  import reg_share_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  reg_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the storage and grant outputs should hold.
  int           m_ptr;
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  logic [1:0]   m_idx;
  logic [15:0]  m_cnt;

  task automatic model_reset();
    m_ptr = 0; m_q = '0; m_gnt = '0; m_idx = '0; m_cnt = '0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs, then advance the DUT.
  task automatic tick();
    int win;
    int cand;
    win = -1;
    if (bus.clr) begin
      m_q   = '0;
      m_gnt = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (win < 0 && bus.req[cand]) win = cand;
      end
      m_gnt = '0;
      if (win >= 0) begin
        m_q        = bus.wdata[win*W +: W];
        m_gnt[win] = 1'b1;
        m_idx      = 2'(win);
        m_ptr      = (win + 1) % N;
        m_cnt      = m_cnt + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = '0; bus.clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.req = 4'b0010;
    bus.wdata[8 +: 8] = 8'hC3;
    tick();
    bus.req = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.q !== 8'h00)    begin n_bad++; $display("FAIL reset_q got=%h want=00", bus.q); end
    n_cmp++; if (bus.qb !== 8'hFF)   begin n_bad++; $display("FAIL reset_qb got=%h want=ff", bus.qb); end
    n_cmp++; if (bus.gnt !== 4'b0)   begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    n_cmp++; if (bus.gnt_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx got=%0d want=0", bus.gnt_idx); end
    n_cmp++; if (bus.wr_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", bus.wr_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    bus.wdata[16 +: 8] = 8'hA5;
    tick();
    bus.req = '0;
    n_cmp++; if (bus.q !== 8'hA5)      begin n_bad++; $display("FAIL single_q got=%h want=a5", bus.q); end
    n_cmp++; if (bus.qb !== 8'h5A)     begin n_bad++; $display("FAIL single_qb got=%h want=5a", bus.qb); end
    n_cmp++; if (bus.gnt !== 4'b0100)  begin n_bad++; $display("FAIL single_gnt got=%b want=0100", bus.gnt); end
    n_cmp++; if (bus.gnt_idx !== 2'd2) begin n_bad++; $display("FAIL single_idx got=%0d want=2", bus.gnt_idx); end
    n_cmp++; if (bus.wr_cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt got=%0d want=1", bus.wr_cnt); end
    tick();
    n_cmp++; if (bus.gnt !== 4'b0000)  begin n_bad++; $display("FAIL single_gnt_drop got=%b want=0000", bus.gnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = 8'h10 + 8'(i * 17);
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (bus.gnt_idx !== 2'(c % N) || bus.q !== 8'h10 + 8'((c % N) * 17)) begin
        n_bad++;
        $display("FAIL rr_cycle%0d got idx=%0d q=%h want idx=%0d q=%h", c, bus.gnt_idx, bus.q,
                 c % N, 8'h10 + 8'((c % N) * 17));
      end
    end
    bus.req = '0;
    n_cmp++; if (bus.wr_cnt !== 16'd8) begin n_bad++; $display("FAIL rr_cnt got=%0d want=8", bus.wr_cnt); end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b1001;
    tick();
    n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_first got=%b want=1000", bus.gnt); end
    bus.req = 4'b0001;
    tick();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_second got=%b want=0001", bus.gnt); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_clear();
    logic [15:0] cnt_before;
    bus.req = 4'b0001;
    bus.wdata[0 +: 8] = 8'h3C;
    tick();
    n_cmp++; if (bus.q !== 8'h3C) begin n_bad++; $display("FAIL clr_pre_q got=%h want=3c", bus.q); end
    cnt_before = m_cnt;
    bus.wdata[0 +: 8] = 8'h77;
    bus.clr = 1'b1;
    tick();
    n_cmp++;
    if (bus.q !== 8'h00 || bus.gnt !== 4'b0 || bus.wr_cnt !== cnt_before) begin
      n_bad++;
      $display("FAIL clr_block got q=%h gnt=%b cnt=%0d want q=00 gnt=0000 cnt=%0d",
               bus.q, bus.gnt, bus.wr_cnt, cnt_before);
    end
    bus.clr = 1'b0;
    tick();
    n_cmp++;
    if (bus.q !== 8'h77 || bus.gnt !== 4'b0001 || bus.wr_cnt !== cnt_before + 16'd1) begin
      n_bad++;
      $display("FAIL clr_deferred got q=%h gnt=%b cnt=%0d want q=77 gnt=0001 cnt=%0d",
               bus.q, bus.gnt, bus.wr_cnt, cnt_before + 16'd1);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N+2+3*W+16-1:0] exp_v, act_v;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      // Clients follow the protocol: drop on grant, otherwise maybe raise with fresh data.
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(1, 0) == 1) begin
          bus.req[i] = 1'b1;
          bus.wdata[i*W +: W] = 8'($urandom);
        end
      end
      bus.clr = ($urandom_range(7, 0) == 0);
      tick();
      exp_v = {m_gnt, m_idx, m_q, ~m_q, m_cnt};
      act_v = {bus.gnt, bus.gnt_idx, bus.q, bus.qb, bus.wr_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL random_cycle%0d got gnt=%b idx=%0d q=%h qb=%h cnt=%0d want gnt=%b idx=%0d q=%h qb=%h cnt=%0d",
                 c, bus.gnt, bus.gnt_idx, bus.q, bus.qb, bus.wr_cnt, m_gnt, m_idx, m_q, ~m_q, m_cnt);
      end
    end
    bus.req = '0;
    bus.clr = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    bus.req = 4'b0001;
    repeat (65535) tick();
    n_cmp++; if (bus.wr_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_full got=%h want=ffff", bus.wr_cnt); end
    tick();
    n_cmp++; if (bus.wr_cnt !== 16'h0000) begin n_bad++; $display("FAIL cnt_wrap got=%h want=0000", bus.wr_cnt); end
    bus.req = '0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    bus.clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_clear();
    test_random();
    test_counter_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
